seu_count_scheduler: RTL
========================

// Module: seu_count_scheduler
// PURPOSE
//  Multi-channel SEU event counter controller. Synchronises and glitch-filters NCH async SEU inputs,
//  then round-robin arbitrates edge events onto one shared increment port of a counter register bank.
//  A req/ack readout port serialises host reads, with optional clear-on-read. Sits between the
//  radiation-test SEU monitors and the TDC readout/config interface.
// PARAMETERS
//  NCH     8    number of SEU channels (2..32)
//  CTR_W   32   width of each event counter
//  FILT    7    filter hold: filtered SEU stays high FILT+1 cycles after synced input drops
//  CH_W    3    channel index width, must equal clog2(NCH)
// PORTS
//  clk          in   1       system clock, all logic on rising edge
//  rst_n        in   1       synchronous active-low reset
//  seu_in       in   NCH     async SEU flags, one per channel
//  rd_req       in   1       read request, level, held until rd_ack
//  rd_ch        in   CH_W    channel to read, stable while rd_req high
//  rd_clear     in   1       clear counter on read, sampled with rd_req
//  rd_ack       out  1       one-cycle pulse, rd_data valid in the same cycle
//  rd_data      out  CTR_W   counter value of rd_ch at the accept cycle
//  rd_ovf       out  1       wrap sticky of rd_ch, valid with rd_ack
//  lost_evt     out  NCH     sticky per channel: edge arrived while pending already set
//  busy         out  1       any pending bit set
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): all counters, pending, sync, filter, ovf, lost_evt=0; rd_ack=0,
//   rd_data=0, busy=0; FSM->IDLE. Reset mid-read drops the request and gives no rd_ack.
//  Per channel: 2-FF sync -> filter (sync=1: hold=FILT, f=1; else hold!=0: hold-=1; else f=0)
//   -> f_d1 register; edge = f & ~f_d1 sets pend[ch].
//  Latency: seu_in high before edge k -> pend set at edge k+4; earliest count at edge k+5.
//  Pulses with synced gap <= FILT+1 cycles merge into one event.
//  Edge on ch with pend[ch]=1 and pend not cleared same cycle -> lost_evt[ch]=1 (sticky to reset).
//  Arbiter: round-robin pointer rr; grant = first pend set, searching rr, rr+1, ... mod NCH.
//   Granted ch: ctr+=1, pend cleared, rr<=grant+1 mod NCH. One increment per cycle maximum.
//   Edge and grant on same ch same cycle: pend stays 1 (new event kept, not lost).
//  Counter wraps 2^CTR_W-1 -> 0 and sets ovf[ch] sticky; ovf cleared only by reset or clear-read.
//  FSM IDLE/READ/ACK:
//   IDLE: rd_req=1 -> READ, latch rd_ch/rd_clear; else arbiter grants.
//   READ: no grant this cycle; rd_data<=ctr[ch], rd_ovf<=ovf[ch]; if clear: ctr,ovf<=0 -> ACK.
//   ACK: rd_ack=1 one cycle, arbiter grants normally -> IDLE. Next request accepted >=1 cycle later.
//  Read-clear never loses events: a pending event on the read ch is counted after READ, so the
//   counter reads 1 afterwards.
//  rd_data/rd_ovf hold their value until the next READ.
//  Worst-case service time for a pending event: NCH cycles plus 2 per interleaved read.
// TESTING
//  1 rst_n=0 for 3 clk, seu_in=all 1 -> all outputs 0, no counts after release until +5 edges.
//  2 seu_in[2] 1 for 1 clk -> ctr[2]=1 at edge 5; rd ch2 -> rd_ack 2 cycles after req, rd_data=1.
//  3 ch0 pulse 1 clk, 1 clk gap, 1 clk pulse -> single count (merge); gap of FILT+3 -> count 2.
//  4 all 8 channels edge same cycle -> counts land ch0..ch7 on 8 consecutive cycles; busy 8 cycles.
//  5 force ctr[5]=2^32-1, one event -> ctr 0, rd_ovf=1; clear-read -> rd_ovf 0 on next read.
//  6 clear-read ch3 while pend[3]=1 -> rd_data=old value, later read=1; lost_evt[3] stays 0.

Source files
------------

// File: rtl/seu_count_scheduler.sv
// seu_count_scheduler: sync/filter SEU flags, round-robin count them, serve req/ack counter reads
module seu_count_scheduler #(
  parameter int NCH   = 8,
  parameter int CTR_W = 32,
  parameter int FILT  = 7,
  parameter int CH_W  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH-1:0]   seu_in_i,
  input  logic             rd_req_i,
  input  logic [CH_W-1:0]  rd_ch_i,
  input  logic             rd_clear_i,
  output logic             rd_ack_o,
  output logic [CTR_W-1:0] rd_data_o,
  output logic             rd_ovf_o,
  output logic [NCH-1:0]   lost_evt_o,
  output logic             busy_o
);
  localparam int HW = $clog2(FILT + 2);
  typedef enum logic [1:0] {IDLE, READ, ACK} state_t;
  state_t state_q, state_d;
  logic [NCH-1:0] sync1_q, sync2_q, filt_q, filt_d1_q, edge_q;
  logic [NCH-1:0] pend_q, pend_d, lost_q, lost_d, ovf_q, gnt_oh;
  logic [HW-1:0] hold_q [NCH];
  logic [CTR_W-1:0] ctr_q [NCH];
  logic [CTR_W-1:0] rd_data_q;
  logic [CH_W-1:0] rr_q, gnt, idx, rd_ch_q;
  logic rd_clear_q, rd_ovf_q, gnt_vld, gnt_en;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      filt_q    <= '0;
      filt_d1_q <= '0;
      edge_q    <= '0;
      for (int c = 0; c < NCH; c++) hold_q[c] <= '0;
    end else begin
      sync1_q   <= seu_in_i;
      sync2_q   <= sync1_q;
      filt_d1_q <= filt_q;
      edge_q    <= filt_q & ~filt_d1_q;
      for (int c = 0; c < NCH; c++) begin
        if (sync2_q[c]) begin
          hold_q[c] <= HW'(FILT);
          filt_q[c] <= 1'b1;
        end else if (hold_q[c] != '0) hold_q[c] <= hold_q[c] - 1'b1;
        else filt_q[c] <= 1'b0;
      end
    end
  end
  // Scan downwards so the last hit is the closest channel at or after rr_q.
  always_comb begin
    gnt_vld = 1'b0;
    gnt     = '0;
    idx     = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      idx = CH_W'((int'(rr_q) + i) % NCH);
      if (pend_q[idx]) begin
        gnt_vld = 1'b1;
        gnt     = idx;
      end
    end
    gnt_en  = (state_q == ACK) || (state_q == IDLE && !rd_req_i);
    gnt_oh  = (gnt_vld && gnt_en) ? (NCH'(1) << gnt) : '0;
    pend_d  = (pend_q & ~gnt_oh) | edge_q;
    lost_d  = lost_q | (edge_q & pend_q & ~gnt_oh);
    state_d = state_q == IDLE ? (rd_req_i ? READ : IDLE) : state_q == READ ? ACK : IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pend_q     <= '0;
      lost_q     <= '0;
      ovf_q      <= '0;
      rr_q       <= '0;
      rd_ch_q    <= '0;
      rd_clear_q <= 1'b0;
      rd_data_q  <= '0;
      rd_ovf_q   <= 1'b0;
      for (int c = 0; c < NCH; c++) ctr_q[c] <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      lost_q  <= lost_d;
      if (state_q == IDLE && rd_req_i) begin
        rd_ch_q    <= rd_ch_i;
        rd_clear_q <= rd_clear_i;
      end
      if (|gnt_oh) begin
        ctr_q[gnt] <= ctr_q[gnt] + 1'b1;
        if (&ctr_q[gnt]) ovf_q[gnt] <= 1'b1;
        rr_q <= (gnt == CH_W'(NCH - 1)) ? '0 : gnt + 1'b1;
      end
      // No grant happens in READ, so the clear never collides with an increment.
      if (state_q == READ) begin
        rd_data_q <= ctr_q[rd_ch_q];
        rd_ovf_q  <= ovf_q[rd_ch_q];
        if (rd_clear_q) begin
          ctr_q[rd_ch_q] <= '0;
          ovf_q[rd_ch_q] <= 1'b0;
        end
      end
    end
  end
  assign rd_ack_o   = (state_q == ACK);
  assign rd_data_o  = rd_data_q;
  assign rd_ovf_o   = rd_ovf_q;
  assign lost_evt_o = lost_q;
  assign busy_o     = |pend_q;
endmodule
